// File: rtl/setuphold_chk_pkg.sv
// ============================================================================
// setuphold_chk_pkg : shared state type and default sizes for setuphold_checker
// Revision 1.0
// ============================================================================
`default_nettype none

package setuphold_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int C_DEF_LAT    = 1;
    localparam int C_DEF_NCASES = 4;
    localparam int C_DEF_CNT_W  = 8;

endpackage

`default_nettype wire

// File: rtl/sh_delay_line.sv
// ============================================================================
// sh_delay_line : LAT-deep shift register producing the expected DUT output
// Revision 1.0
// ============================================================================
`default_nettype none

module sh_delay_line
    import setuphold_chk_pkg::*;
#(
    parameter int LAT = C_DEF_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [LAT-1:0] r_sr;

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= d;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[LAT-2:0], d};
                end
            end
        end
    endgenerate

    assign q = r_sr[LAT-1];

endmodule

`default_nettype wire

// File: rtl/setuphold_checker.sv
// ============================================================================
// setuphold_checker : compares DUT q against d delayed LAT cycles, per case.
// Optional SETUPHOLD_X_CHECK_EN adds x_seen and treats unknown q as mismatch.
// Revision 1.0
// ============================================================================
`default_nettype none

module setuphold_checker
    import setuphold_chk_pkg::*;
#(
    parameter  int LAT    = C_DEF_LAT,
    parameter  int NCASES = C_DEF_NCASES,
    parameter  int CNT_W  = C_DEF_CNT_W,
    localparam int IDX_W  = (NCASES > 1) ? $clog2(NCASES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              case_next,
    input  logic              d_exp,
    input  logic              q_obs,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  case_idx,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [NCASES-1:0] case_fail,
    output logic              pass
`ifdef SETUPHOLD_X_CHECK_EN
    ,
    output logic              x_seen
`endif
);

    localparam int FILL_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FILL_W-1:0] r_fill_cnt;
    logic              w_exp;
    logic              w_mismatch;
    logic              w_start_ok;
    logic              w_fill_last;
    logic              w_last_case;
    logic              w_in_check;

    sh_delay_line #(
        .LAT (LAT)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (d_exp),
        .q   (w_exp)
    );

    assign w_in_check  = (r_state == ST_CHECK);
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_fill_last = (r_fill_cnt == FILL_W'(LAT - 1));
    assign w_last_case = (case_idx == IDX_W'(NCASES - 1));

`ifdef SETUPHOLD_X_CHECK_EN
    logic w_q_unknown;
    assign w_q_unknown = $isunknown(q_obs);
    assign w_mismatch  = w_in_check && (w_q_unknown || (q_obs != w_exp));
`else
    // Two-state compare: an unknown q_obs resolves to a non-true condition.
    assign w_mismatch  = w_in_check && (q_obs != w_exp);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_fill_last) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (case_next) begin
                    w_state_nxt = w_last_case ? ST_DONE : ST_FILL;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A mismatch in the case_next cycle is booked against the old case_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill_cnt <= '0;
            case_idx   <= '0;
            err_cnt    <= '0;
            case_fail  <= '0;
        end else if (w_start_ok) begin
            r_fill_cnt <= '0;
            case_idx   <= '0;
            err_cnt    <= '0;
            case_fail  <= '0;
        end else begin
            if (r_state == ST_FILL) begin
                r_fill_cnt <= w_fill_last ? '0 : r_fill_cnt + 1'b1;
            end
            if (w_mismatch) begin
                if (err_cnt != {CNT_W{1'b1}}) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                case_fail[case_idx] <= 1'b1;
            end
            if (w_in_check && case_next && !w_last_case) begin
                case_idx <= case_idx + 1'b1;
            end
        end
    end

`ifdef SETUPHOLD_X_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_seen <= 1'b0;
        end else if (w_start_ok) begin
            x_seen <= 1'b0;
        end else if (w_in_check && w_q_unknown) begin
            x_seen <= 1'b1;
        end
    end
`endif

    assign busy = (r_state == ST_FILL) || (r_state == ST_CHECK);
    assign done = (r_state == ST_DONE);
    assign pass = (r_state == ST_DONE) && (err_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_setuphold_checker.sv
// ============================================================================
// tb_setuphold_checker : scoreboard bench for setuphold_checker
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_setuphold_checker;

    localparam int LAT    = 1;
    localparam int NCASES = 4;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              case_next;
    logic              d_exp;
    logic              q_obs;
    logic              busy;
    logic              done;
    logic [1:0]        case_idx;
    logic [CNT_W-1:0]  err_cnt;
    logic [NCASES-1:0] case_fail;
    logic              pass;
`ifdef SETUPHOLD_X_CHECK_EN
    logic              x_seen;
`endif

    logic flip;
    logic xinj;
    logic d_zero;
    logic q_prev = 1'b0;
    logic done_q = 1'b0;

    typedef struct {
        int                err;
        logic [NCASES-1:0] fail;
        logic              xs;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int                n_total = 0;
    int                n_bad   = 0;
    int                m_err;
    logic [NCASES-1:0] m_fail;
    logic              m_xs;

    setuphold_checker #(
        .LAT    (LAT),
        .NCASES (NCASES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .case_next (case_next),
        .d_exp     (d_exp),
        .q_obs     (q_obs),
        .busy      (busy),
        .done      (done),
        .case_idx  (case_idx),
        .err_cnt   (err_cnt),
        .case_fail (case_fail),
        .pass      (pass)
`ifdef SETUPHOLD_X_CHECK_EN
        ,
        .x_seen    (x_seen)
`endif
    );

    always #5 clk = ~clk;

    // Ideal DUT with one cycle clk-to-q; flip/xinj inject faults.
    always @(posedge clk) q_prev <= d_exp;
    assign q_obs = xinj ? 1'bx : (q_prev ^ flip);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        done_q <= done;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("err_cnt", 32'(err_cnt), 32'(mon_e.err));
                chk("case_fail", 32'(case_fail), 32'(mon_e.fail));
                chk("pass", 32'(pass), 32'(mon_e.err == 0));
                chk("case_idx_done", 32'(case_idx), 32'(NCASES - 1));
                chk("busy_done", 32'(busy), 32'd0);
`ifdef SETUPHOLD_X_CHECK_EN
                chk("x_seen", 32'(x_seen), 32'(mon_e.xs));
`endif
            end
        end
    end

    task automatic cyc(input logic s, input logic cn, input logic fl, input logic xi);
        @(posedge clk);
        #1;
        start     = s;
        case_next = cn;
        flip      = fl;
        xinj      = xi;
        d_exp     = d_zero ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic begin_run();
        m_err  = 0;
        m_fail = '0;
        m_xs   = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_case(input int c, input int nchk, input logic [31:0] mask,
                            input logic [31:0] xmask, input logic fill_flip,
                            input logic fill_cn, input logic start_mid);
        for (int i = 0; i < LAT; i++) begin
            cyc(1'b0, fill_cn, fill_flip, 1'b0);
            if (i == 0) begin
                chk("case_idx_fill", 32'(case_idx), 32'(c));
                chk("busy_run", 32'(busy), 32'd1);
            end
        end
        for (int i = 0; i < nchk; i++) begin
            cyc(start_mid && (i == 0), (i == nchk - 1), mask[i], xmask[i]);
            if (mask[i]) begin
                m_err++;
                m_fail[c] = 1'b1;
            end
`ifdef SETUPHOLD_X_CHECK_EN
            if (xmask[i]) begin
                m_err++;
                m_fail[c] = 1'b1;
                m_xs      = 1'b1;
            end
`endif
        end
    endtask

    task automatic end_run();
        exp_t e;
        e.err  = (m_err > SAT) ? SAT : m_err;
        e.fail = m_fail;
        e.xs   = m_xs;
        sb.push_back(e);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("done_hold", 32'(done), 32'd1);
        chk("err_hold", 32'(err_cnt), 32'(e.err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; case_next = 1'b0; d_exp = 1'b0;
        flip = 1'b0; xinj = 1'b0; d_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_fail", 32'(case_fail), 32'd0);
        chk("rst_idx", 32'(case_idx), 32'd0);
        rst = 1'b0;

        // Clean run: every case matches.
        begin_run();
        for (int c = 0; c < NCASES; c++) run_case(c, 5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        end_run();

        // One flipped CHECK cycle in case 1; FILL flips, FILL case_next and busy start ignored.
        begin_run();
        run_case(0, 4, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        run_case(1, 5, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(2, 4, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        run_case(3, 4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        end_run();

        // Mismatch coincident with case_next in case 2.
        begin_run();
        run_case(0, 3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(1, 3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(2, 4, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(3, 3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        end_run();

        // Saturation: 20 mismatching cycles on a 4-bit counter.
        begin_run();
        run_case(0, 21, 32'h000F_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(1, 2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(2, 2, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(3, 2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        end_run();

        // Reset during CHECK of case 2 after errors have accumulated.
        begin_run();
        run_case(0, 3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(1, 3, 32'h3, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        chk("mid_rst_fail", 32'(case_fail), 32'd0);
        chk("mid_rst_idx", 32'(case_idx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_after_rst", 32'(busy), 32'd0);
        begin_run();
        for (int c = 0; c < NCASES; c++) run_case(c, 3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        end_run();

        // Unknown q_obs for one cycle in case 3 (expected value held at 0).
        d_zero = 1'b1;
        begin_run();
        run_case(0, 2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(1, 2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(2, 2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_case(3, 4, 32'h0, 32'h2, 1'b0, 1'b0, 1'b0);
        end_run();
        d_zero = 1'b0;

        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
